// File: rtl/calc_rr_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// calc_rr_scheduler_pkg
//   Shared definitions for the round-robin calculator scheduler:
//   default widths, calculator opcode encoding and scheduler FSM states.
// -----------------------------------------------------------------------------
package calc_rr_scheduler_pkg;

  localparam int NUM_REQ_D        = 4;
  localparam int DATA_W_D         = 3;
  localparam int OP_W_D           = 2;
  localparam int TIMEOUT_CYCLES_D = 16;
  localparam int CNT_W_D          = 5;

  // Calculator opcodes as seen on calc_op.
  typedef enum logic [1:0] {
    OP_XOR = 2'd0,
    OP_AND = 2'd1,
    OP_SUB = 2'd2,
    OP_ADD = 2'd3
  } calc_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/calc_rr_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// calc_rr_scheduler_rr_arbiter
//   Combinational round-robin pick: first set request bit scanning upward
//   from ptr, wrapping at NUM_REQ.
// Ports:
//   req      in   request vector
//   ptr      in   index with highest priority this cycle
//   any      out  at least one request is set
//   pick     out  one-hot winner (zero when any = 0)
//   pick_idx out  binary index of the winner
// -----------------------------------------------------------------------------
module calc_rr_scheduler_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               any,
  output logic [NUM_REQ-1:0] pick,
  output logic [IDX_W-1:0]   pick_idx
);

  int               slot;
  logic [IDX_W-1:0] slot_idx;

  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    any      = 1'b0;
    pick     = '0;
    pick_idx = '0;
    slot     = 0;
    slot_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      slot = int'(ptr) + k;
      if (slot >= NUM_REQ) slot = slot - NUM_REQ;
      slot_idx = IDX_W'(slot);
      // Only the first hit in scan order wins.
      if (!any && req[slot_idx]) begin
        any            = 1'b1;
        pick[slot_idx] = 1'b1;
        pick_idx       = slot_idx;
      end
    end
  end

endmodule

// File: rtl/calc_rr_scheduler.sv
// -----------------------------------------------------------------------------
// calc_rr_scheduler
//   Shares one four-op calculator among NUM_REQ requesters. A round-robin
//   winner's operands are latched, one calculator run is sequenced and the
//   result is returned to that winner. A watchdog aborts a run whose Done
//   never arrives and returns an error response instead.
// Ports:
//   clk, reset                      clock, async active-low reset
//   req / req_op / req_in1 / req_in2 per-requester level request and operands
//   gnt                             one-hot pulse when operands are captured
//   rsp_valid / rsp_data / rsp_err  one-hot result pulse, result, abort flag
//   busy                            high whenever the FSM is not idle
//   calc_go / calc_op / calc_in1 / calc_in2 / calc_abort   calculator drive
//   calc_done / calc_out            calculator completion and result
// All outputs are registered.
// -----------------------------------------------------------------------------
module calc_rr_scheduler
  import calc_rr_scheduler_pkg::*;
#(
  parameter int NUM_REQ        = NUM_REQ_D,
  parameter int IDX_W          = $clog2(NUM_REQ),
  parameter int DATA_W         = DATA_W_D,
  parameter int OP_W           = OP_W_D,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_D,
  parameter int CNT_W          = CNT_W_D
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  input  logic [NUM_REQ*DATA_W-1:0] req_in1,
  input  logic [NUM_REQ*DATA_W-1:0] req_in2,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic                      busy,
  output logic                      calc_go,
  output logic [OP_W-1:0]           calc_op,
  output logic [DATA_W-1:0]         calc_in1,
  output logic [DATA_W-1:0]         calc_in2,
  output logic                      calc_abort,
  input  logic                      calc_done,
  input  logic [DATA_W-1:0]         calc_out
);

  state_e             state;
  logic [IDX_W-1:0]   ptr;
  logic [NUM_REQ-1:0] win;
  logic [CNT_W-1:0]   cnt;

  logic               any;
  logic [NUM_REQ-1:0] pick;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   ptr_next;
  logic [OP_W-1:0]    sel_op;
  logic [DATA_W-1:0]  sel_in1;
  logic [DATA_W-1:0]  sel_in2;

  calc_rr_scheduler_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req      (req),
    .ptr      (ptr),
    .any      (any),
    .pick     (pick),
    .pick_idx (pick_idx)
  );

  assign sel_op   = req_op [pick_idx*OP_W   +: OP_W];
  assign sel_in1  = req_in1[pick_idx*DATA_W +: DATA_W];
  assign sel_in2  = req_in2[pick_idx*DATA_W +: DATA_W];
  // The winner drops to lowest priority; explicit wrap keeps this correct
  // for non-power-of-two NUM_REQ.
  assign ptr_next = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      ptr        <= '0;
      win        <= '0;
      cnt        <= '0;
      gnt        <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      busy       <= 1'b0;
      calc_go    <= 1'b0;
      calc_op    <= '0;
      calc_in1   <= '0;
      calc_in2   <= '0;
      calc_abort <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      // Pulse outputs default low and are raised only on the transition
      // that owns them.
      gnt        <= '0;
      rsp_valid  <= '0;
      calc_go    <= 1'b0;
      calc_abort <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any) begin
            calc_op  <= sel_op;
            calc_in1 <= sel_in1;
            calc_in2 <= sel_in2;
            gnt      <= pick;
            win      <= pick;
            ptr      <= ptr_next;
            busy     <= 1'b1;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          calc_go <= 1'b1;
          cnt     <= '0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          cnt <= cnt + CNT_W'(1);
          // Done takes precedence over a coincident timeout.
          if (calc_done) begin
            rsp_data  <= calc_out;
            rsp_err   <= 1'b0;
            rsp_valid <= win;
            state     <= S_RESP;
          end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            calc_abort <= 1'b1;
            rsp_err    <= 1'b1;
            rsp_data   <= '0;
            rsp_valid  <= win;
            state      <= S_RESP;
          end
        end
        S_RESP: begin
          rsp_err  <= 1'b0;
          rsp_data <= '0;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_rr_scheduler.sv
// -----------------------------------------------------------------------------
// tb_calc_rr_scheduler
//   Drives requesters and a behavioural calculator stub on the falling edge;
//   expected grants and responses are queued when stimulus is applied and
//   popped when the DUT pulses gnt / rsp_valid.
// -----------------------------------------------------------------------------
module tb_calc_rr_scheduler;
  import calc_rr_scheduler_pkg::*;

  localparam int NR  = 4;
  localparam int DW  = 3;
  localparam int OW  = 2;
  localparam int TO  = 16;

  typedef struct {
    int         idx;
    logic [2:0] data;
    logic       err;
  } exp_t;

  logic            clk;
  logic            reset;
  logic [NR-1:0]   req;
  logic [NR*OW-1:0] req_op;
  logic [NR*DW-1:0] req_in1;
  logic [NR*DW-1:0] req_in2;
  logic [NR-1:0]   gnt;
  logic [NR-1:0]   rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            rsp_err;
  logic            busy;
  logic            calc_go;
  logic [OW-1:0]   calc_op;
  logic [DW-1:0]   calc_in1;
  logic [DW-1:0]   calc_in2;
  logic            calc_abort;
  logic            calc_done;
  logic [DW-1:0]   calc_out;

  calc_rr_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_op     (req_op),
    .req_in1    (req_in1),
    .req_in2    (req_in2),
    .gnt        (gnt),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .busy       (busy),
    .calc_go    (calc_go),
    .calc_op    (calc_op),
    .calc_in1   (calc_in1),
    .calc_in2   (calc_in2),
    .calc_abort (calc_abort),
    .calc_done  (calc_done),
    .calc_out   (calc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  exp_t       sb_q[$];
  int         gnt_q[$];
  logic [NR-1:0] rereq_mask = '0;
  int         cyc = 0;
  int         go_cyc = 0;
  bit         go_due = 0;
  bit         rsp_due = 0;
  int         lat = 3;
  bit         stall = 0;
  bit         spurious = 0;
  int         pend = 0;
  logic [2:0] stub_res = '0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic [2:0] stub_calc(input logic [1:0] op, input logic [2:0] a,
                                           input logic [2:0] b);
    case (op)
      2'd0:    return a ^ b;
      2'd1:    return a & b;
      2'd2:    return a - b;
      default: return a + b;
    endcase
  endfunction

  // One falling edge: observe DUT outputs, then update requesters and stub.
  task automatic tick();
    exp_t r;
    int   e;
    @(negedge clk);
    cyc++;
    if (go_due) begin
      check("calc_go_lat", calc_go, 1);
      go_due = 0;
      go_cyc = cyc;
    end else if (calc_go) begin
      check("calc_go_unexp", calc_go, 0);
    end
    if (gnt != '0) begin
      if (gnt_q.size() == 0) check("gnt_unexp", gnt, 0);
      else begin
        e = gnt_q.pop_front();
        check("gnt", gnt, 32'(1 << e));
        check("gnt_busy", busy, 1);
      end
      go_due = 1;
    end
    if (rsp_due) begin
      check("rsp_lat", rsp_valid != '0, 1);
      rsp_due = 0;
    end
    if (rsp_valid != '0) begin
      if (sb_q.size() == 0) check("rsp_unexp", rsp_valid, 0);
      else begin
        r = sb_q.pop_front();
        check("rsp_valid", rsp_valid, 32'(1 << r.idx));
        check("rsp_data", rsp_data, r.data);
        check("rsp_err", rsp_err, r.err);
        check("calc_abort", calc_abort, r.err);
        if (calc_abort) check("abort_dist", cyc - go_cyc, TO);
      end
      for (int i = 0; i < NR; i++) begin
        if (rsp_valid[i]) begin
          if (rereq_mask[i]) rereq_mask[i] = 1'b0;
          else req[i] = 1'b0;
        end
      end
    end else if (calc_abort) begin
      check("abort_orphan", calc_abort, 0);
    end
    // Calculator stub.
    calc_done = 1'b0;
    calc_out  = '0;
    if (!reset || calc_abort) pend = 0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        calc_done = 1'b1;
        calc_out  = stub_res;
      end
    end
    if (calc_go) begin
      stub_res = stub_calc(calc_op, calc_in1, calc_in2);
      pend     = stall ? 0 : lat;
    end
    if (spurious) begin
      calc_done = 1'b1;
      calc_out  = 3'd5;
      spurious  = 0;
    end
    if (calc_done && busy) rsp_due = 1;
  endtask

  task automatic set_req(input int i, input calc_op_e op, input logic [2:0] a,
                         input logic [2:0] b);
    req_op[i*OW +: OW]  = op;
    req_in1[i*DW +: DW] = a;
    req_in2[i*DW +: DW] = b;
    req[i]              = 1'b1;
  endtask

  task automatic expect_run(input int i, input logic [2:0] d, input logic e);
    exp_t x;
    x.idx = i;
    x.data = d;
    x.err = e;
    gnt_q.push_back(i);
    sb_q.push_back(x);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((gnt_q.size() != 0 || sb_q.size() != 0 || busy) && n < 400) begin
      tick();
      n++;
    end
    check({tag, "_drain"}, gnt_q.size() + sb_q.size(), 0);
    tick();
    tick();
  endtask

  task automatic wait_gnt();
    int n = 0;
    while (!busy && n < 10) begin
      tick();
      n++;
    end
  endtask

  initial begin
    reset     = 1'b0;
    req       = '0;
    req_op    = '0;
    req_in1   = '0;
    req_in2   = '0;
    calc_done = 1'b0;
    calc_out  = '0;

    // Reset state.
    tick();
    tick();
    check("reset_outs", {gnt, rsp_valid, rsp_data, rsp_err, busy, calc_go, calc_op,
                         calc_in1, calc_in2, calc_abort}, 0);
    reset = 1'b1;
    tick();

    // Reset in the middle of WAIT: run is lost silently.
    stall = 1;
    set_req(1, OP_ADD, 3'd5, 3'd2);
    gnt_q.push_back(1);
    repeat (6) tick();
    check("mid_busy", busy, 1);
    #2 reset = 1'b0;
    #1 check("mid_reset_outs", {gnt, rsp_valid, rsp_data, rsp_err, busy, calc_go, calc_op,
                                calc_in1, calc_in2, calc_abort}, 0);
    req     = '0;
    go_due  = 0;
    rsp_due = 0;
    tick();
    reset = 1'b1;
    stall = 0;
    repeat (4) tick();
    check("post_reset_busy", busy, 0);

    // Fairness: all four request; requester 0 re-requests after its response.
    for (int i = 0; i < NR; i++) set_req(i, OP_ADD, 3'(i), 3'd1);
    rereq_mask = 4'b0001;
    for (int i = 0; i < NR; i++) expect_run(i, 3'(i + 1), 1'b0);
    expect_run(0, 3'd1, 1'b0);
    drain("fair");

    // Single requester 2, four opcodes; operands changed after the grant.
    set_req(2, OP_ADD, 3'd6, 3'd1);
    expect_run(2, 3'd7, 1'b0);
    wait_gnt();
    req_in1[2*DW +: DW] = 3'd0;
    req_op[2*OW +: OW]  = OP_XOR;
    drain("add");
    set_req(2, OP_SUB, 3'd6, 3'd1);
    expect_run(2, 3'd5, 1'b0);
    drain("sub");
    set_req(2, OP_AND, 3'd6, 3'd1);
    expect_run(2, 3'd0, 1'b0);
    drain("and");
    set_req(2, OP_XOR, 3'd6, 3'd1);
    expect_run(2, 3'd7, 1'b0);
    drain("xor");

    // Wrap priority: pointer now at 3, requesters 3 and 0 together.
    set_req(3, OP_SUB, 3'd1, 3'd6);
    set_req(0, OP_ADD, 3'd7, 3'd7);
    expect_run(3, 3'd3, 1'b0);
    expect_run(0, 3'd6, 1'b0);
    drain("wrap");

    // Watchdog abort; requester 0 pulses req briefly and is never served.
    stall = 1;
    set_req(1, OP_ADD, 3'd2, 3'd3);
    expect_run(1, 3'd0, 1'b1);
    wait_gnt();
    tick();
    set_req(0, OP_ADD, 3'd1, 3'd1);
    repeat (3) tick();
    req[0] = 1'b0;
    drain("timeout");
    stall = 0;
    set_req(1, OP_ADD, 3'd2, 3'd3);
    expect_run(1, 3'd5, 1'b0);
    drain("after_to");

    // Done arriving in the timeout cycle wins.
    lat = TO - 1;
    set_req(3, OP_XOR, 3'd5, 3'd3);
    expect_run(3, 3'd6, 1'b0);
    drain("done_at_to");
    lat = 3;

    // Spurious calc_done while idle.
    spurious = 1;
    repeat (4) tick();
    check("spur_busy", busy, 0);
    check("spur_gnt", gnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
